// File: rtl/axis_icrc_append_pkg.sv
// axis_icrc_append_pkg: shared ICRC constants and the append FSM state encoding
package axis_icrc_append_pkg;
    localparam logic [31:0] ICRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] ICRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] ICRC_XOROUT    = 32'hFFFFFFFF;
    localparam int          ICRC_BYTES     = 4;
    typedef enum logic {ST_DATA, ST_EXTRA} state_t;
endpackage

// File: rtl/icrc32_calc.sv
// icrc32_calc: combinational reflected CRC-32 update over the kept bytes of one beat
module icrc32_calc
    import axis_icrc_append_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [31:0]             crc_in,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [DATA_WIDTH/8-1:0] keep,
    output logic [31:0]             crc_out
);
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (keep[i]) begin
                crc_out = crc_out ^ {24'h0, data[8*i +: 8]};
                for (int b = 0; b < 8; b++)
                    crc_out = crc_out[0] ? (crc_out >> 1) ^ ICRC_POLY_REFL : crc_out >> 1;
            end
        end
    end
endmodule

// File: rtl/axis_icrc_append.sv
// axis_icrc_append: CRCs the masked stream and appends the ICRC to the unmasked payload
module axis_icrc_append
    import axis_icrc_append_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_masked_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_masked_tkeep,
    input  logic                    s_axis_masked_tvalid,
    output logic                    s_axis_masked_tready,
    input  logic                    s_axis_masked_tlast,
    input  logic [USER_WIDTH-1:0]   s_axis_masked_tuser,
    input  logic [DATA_WIDTH-1:0]   s_axis_not_masked_tdata,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_tuser
);
    localparam int N  = DATA_WIDTH/8;
    localparam int KW = $clog2(N) + 1;

    state_t                r_state, w_state_next;
    logic [31:0]           r_crc, w_crc_next, w_icrc, r_extra;
    logic [2:0]            r_extra_cnt;
    logic [USER_WIDTH-1:0] r_extra_user;
    logic [KW-1:0]         w_k;
    logic                  w_need_extra, w_accept;
    logic                  r_s_ready, r_int_ready, w_ready_early;
    logic [DATA_WIDTH-1:0] w_last_data, w_int_data, r_m_data, r_tmp_data;
    logic [N-1:0]          w_last_keep, w_int_keep, r_m_keep, r_tmp_keep;
    logic                  w_int_valid, w_int_last, r_m_valid, r_m_last, r_tmp_valid, r_tmp_last;
    logic [USER_WIDTH-1:0] w_int_user, r_m_user, r_tmp_user;
    logic                  w_m_valid_next, w_tmp_valid_next, w_to_out, w_to_tmp, w_tmp_to_out;

    icrc32_calc #(.DATA_WIDTH(DATA_WIDTH)) u_crc (
        .crc_in (r_crc),
        .data   (s_axis_masked_tdata),
        .keep   (s_axis_masked_tkeep),
        .crc_out(w_crc_next)
    );

    assign w_icrc       = w_crc_next ^ ICRC_XOROUT;
    assign w_accept     = s_axis_masked_tvalid && r_s_ready && r_state == ST_DATA;
    assign w_need_extra = int'(w_k) > N - ICRC_BYTES;

    always_comb begin
        w_k = '0;
        for (int i = 0; i < N; i++) w_k = w_k + KW'(s_axis_masked_tkeep[i]);
    end

    // Last beat: payload in lanes below k, ICRC bytes right after, zeros beyond.
    always_comb begin
        w_last_data = '0;
        w_last_keep = '0;
        for (int i = 0; i < N; i++) begin
            w_last_keep[i] = i < int'(w_k) + ICRC_BYTES;
            if (i < int'(w_k))
                w_last_data[8*i +: 8] = s_axis_not_masked_tdata[8*i +: 8];
            else if (i < int'(w_k) + ICRC_BYTES)
                w_last_data[8*i +: 8] = 8'(w_icrc >> (8*(i - int'(w_k))));
        end
    end

    always_comb begin
        w_state_next = r_state == ST_EXTRA ? (r_int_ready ? ST_DATA : ST_EXTRA)
                     : (w_accept && s_axis_masked_tlast && w_need_extra) ? ST_EXTRA : ST_DATA;
        w_int_valid  = r_state == ST_EXTRA ? r_int_ready : w_accept;
        w_int_data   = r_state == ST_EXTRA ? DATA_WIDTH'(r_extra)
                     : s_axis_masked_tlast ? w_last_data : s_axis_not_masked_tdata;
        w_int_keep   = r_state == ST_EXTRA ? N'((32'd1 << r_extra_cnt) - 32'd1)
                     : s_axis_masked_tlast ? w_last_keep : s_axis_masked_tkeep;
        w_int_last   = r_state == ST_EXTRA ? 1'b1 : s_axis_masked_tlast && !w_need_extra;
        w_int_user   = r_state == ST_EXTRA ? r_extra_user : s_axis_masked_tuser;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_DATA;
            r_crc   <= ICRC_INIT;
        end else begin
            r_state <= w_state_next;
            if (w_accept) r_crc <= s_axis_masked_tlast ? ICRC_INIT : w_crc_next;
        end
    end

    // ICRC bytes that did not fit, pre-shifted down to lane 0 for the extra beat.
    always_ff @(posedge clk) begin
        if (w_accept && s_axis_masked_tlast && w_need_extra) begin
            r_extra      <= w_icrc >> (8*(N - int'(w_k)));
            r_extra_cnt  <= 3'(ICRC_BYTES - (N - int'(w_k)));
            r_extra_user <= s_axis_masked_tuser;
        end
    end

    always_comb begin
        w_ready_early    = m_axis_tready || (!r_m_valid && !r_tmp_valid);
        w_m_valid_next   = r_m_valid;
        w_tmp_valid_next = r_tmp_valid;
        w_to_out         = 1'b0;
        w_to_tmp         = 1'b0;
        w_tmp_to_out     = 1'b0;
        if (r_int_ready) begin
            if (m_axis_tready || !r_m_valid) begin
                w_m_valid_next = w_int_valid;
                w_to_out       = 1'b1;
            end else begin
                w_tmp_valid_next = w_int_valid;
                w_to_tmp         = 1'b1;
            end
        end else if (m_axis_tready) begin
            w_m_valid_next   = r_tmp_valid;
            w_tmp_valid_next = 1'b0;
            w_tmp_to_out     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_keep    <= '0;
            r_m_last    <= 1'b0;
            r_m_user    <= '0;
            r_tmp_valid <= 1'b0;
            r_int_ready <= 1'b0;
            r_s_ready   <= 1'b0;
        end else begin
            r_m_valid   <= w_m_valid_next;
            r_tmp_valid <= w_tmp_valid_next;
            r_int_ready <= w_ready_early;
            r_s_ready   <= w_ready_early && w_state_next == ST_DATA;
            if (w_to_out) begin
                r_m_data <= w_int_data;
                r_m_keep <= w_int_keep;
                r_m_last <= w_int_last;
                r_m_user <= w_int_user;
            end else if (w_tmp_to_out) begin
                r_m_data <= r_tmp_data;
                r_m_keep <= r_tmp_keep;
                r_m_last <= r_tmp_last;
                r_m_user <= r_tmp_user;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_to_tmp) begin
            r_tmp_data <= w_int_data;
            r_tmp_keep <= w_int_keep;
            r_tmp_last <= w_int_last;
            r_tmp_user <= w_int_user;
        end
    end

    assign s_axis_masked_tready = r_s_ready;
    assign m_axis_tvalid        = r_m_valid;
    assign m_axis_tdata         = r_m_data;
    assign m_axis_tkeep         = r_m_keep;
    assign m_axis_tlast         = r_m_last;
    assign m_axis_tuser         = r_m_user;
endmodule

// File: tb/tb_axis_icrc_append.sv
// tb_axis_icrc_append: scoreboard bench for ICRC append with directed and backpressured packets
module tb_axis_icrc_append;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_mdata = '0, s_nmdata = '0;
    logic [7:0]  s_keep = '0;
    logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic [0:0]  s_user = '0;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tlast;
    logic        m_tready = 1'b1;
    logic [0:0]  m_tuser;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [0:0]  u;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] pkt_nm[$], pkt_m[$];
    int         checks = 0, errors = 0, nbeats = 0, npushed = 0, mode = 0;

    always #5 clk = ~clk;

    axis_icrc_append #(.DATA_WIDTH(64), .USER_WIDTH(1)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .s_axis_masked_tdata    (s_mdata),
        .s_axis_masked_tkeep    (s_keep),
        .s_axis_masked_tvalid   (s_valid),
        .s_axis_masked_tready   (s_ready),
        .s_axis_masked_tlast    (s_last),
        .s_axis_masked_tuser    (s_user),
        .s_axis_not_masked_tdata(s_nmdata),
        .m_axis_tdata           (m_tdata),
        .m_axis_tkeep           (m_tkeep),
        .m_axis_tvalid          (m_tvalid),
        .m_axis_tready          (m_tready),
        .m_axis_tlast           (m_tlast),
        .m_axis_tuser           (m_tuser)
    );

    // mode 0: always ready, 1: random backpressure, 2: stalled
    always @(posedge clk) begin
        #2;
        m_tready = mode == 2 ? 1'b0 : mode == 1 ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            beat_t a, e;
            a.d = m_tdata;
            a.k = m_tkeep;
            a.l = m_tlast;
            a.u = m_tuser;
            checks++;
            nbeats++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_beat unexpected got d=%h k=%h l=%b u=%b expected none", a.d, a.k, a.l, a.u);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL out_beat%0d got d=%h k=%h l=%b u=%b expected d=%h k=%h l=%b u=%b",
                             nbeats, a.d, a.k, a.l, a.u, e.d, e.k, e.l, e.u);
                end
            end
        end
    end

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", n, got, exp);
        end
    endtask

    task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        beat_t b;
        b.d = d;
        b.k = k;
        b.l = l;
        b.u = u;
        exp_q.push_back(b);
        npushed++;
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        c = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        return c;
    endfunction

    task automatic send_beat(input logic [63:0] md, input logic [63:0] nmd, input logic [7:0] k,
                             input logic l, input logic u);
        bit done = 0;
        s_mdata  = md;
        s_nmdata = nmd;
        s_keep   = k;
        s_last   = l;
        s_user   = u;
        s_valid  = 1'b1;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            done = s_ready;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got ready=0 expected ready=1");
        end
    endtask

    task automatic load_str(input string s, input bit ff);
        pkt_nm.delete();
        pkt_m.delete();
        for (int i = 0; i < s.len(); i++) begin
            pkt_nm.push_back(s[i]);
            pkt_m.push_back(ff ? 8'hFF : s[i]);
        end
    endtask

    task automatic send_pkt(input logic u, input bit empty_last);
        logic [31:0] c = 32'hFFFFFFFF;
        logic [7:0]  ob[$];
        logic [63:0] d, dm;
        logic [7:0]  k;
        int          nb;
        foreach (pkt_m[i]) c = crc_upd(c, pkt_m[i]);
        c = ~c;
        ob = pkt_nm;
        for (int i = 0; i < 4; i++) ob.push_back(c[8*i +: 8]);
        for (int b = 0; b * 8 < ob.size(); b++) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 8; j++)
                if (b * 8 + j < ob.size()) begin
                    d[8*j +: 8] = ob[b*8+j];
                    k[j] = 1'b1;
                end
            push(d, k, (b + 1) * 8 >= ob.size(), u);
        end
        nb = (pkt_nm.size() + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            d  = '0;
            dm = '0;
            k  = '0;
            for (int j = 0; j < 8; j++)
                if (b * 8 + j < pkt_nm.size()) begin
                    d[8*j +: 8]  = pkt_nm[b*8+j];
                    dm[8*j +: 8] = pkt_m[b*8+j];
                    k[j] = 1'b1;
                end
            send_beat(dm, d, k, b == nb - 1 && !empty_last, u);
        end
        if (empty_last) send_beat('0, '0, 8'h00, 1'b1, u);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 5000 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tkeep", m_tkeep, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tuser", m_tuser, 0);
        chk("rst_sready", s_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("sready_after_rst", s_ready, 1);

        // "123456789", last beat k=1: ICRC 0xCBF43926 fits in lanes 1..4
        push(64'h3837363534333231, 8'hFF, 1'b0, 1'b1);
        push(64'h000000CBF4392639, 8'h1F, 1'b1, 1'b1);
        send_beat(64'h3837363534333231, 64'h3837363534333231, 8'hFF, 1'b0, 1'b1);
        send_beat(64'h39, 64'h39, 8'h01, 1'b1, 1'b1);
        s_valid = 1'b0;

        // "1234" + "56789": k=5 overflows, CB spills into an extra beat
        push(64'h0000000034333231, 8'h0F, 1'b0, 1'b0);
        push(64'hF439263938373635, 8'hFF, 1'b0, 1'b0);
        push(64'h00000000000000CB, 8'h01, 1'b1, 1'b0);
        send_beat(64'h34333231, 64'h34333231, 8'h0F, 1'b0, 1'b0);
        send_beat(64'h3938373635, 64'h3938373635, 8'h1F, 1'b1, 1'b0);
        s_valid = 1'b0;
        chk("sready_extra_slot", s_ready, 0);
        @(posedge clk);
        #1;
        chk("sready_after_extra", s_ready, 1);

        load_str("123456789", 1'b1);
        send_pkt(1'b1, 1'b0);
        load_str("12345678", 1'b0);
        send_pkt(1'b0, 1'b1);
        drain();

        // reset with two beats stuck in the output skid
        mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_beat(64'h1111111111111111, 64'h2222222222222222, 8'hFF, 1'b0, 1'b0);
        send_beat(64'h3333333333333333, 64'h4444444444444444, 8'hFF, 1'b0, 1'b0);
        s_valid = 1'b0;
        chk("stalled_tvalid", m_tvalid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("tvalid_after_midrst", m_tvalid, 0);
        rst  = 1'b0;
        mode = 0;
        exp_q.delete();
        load_str("RoCEv2 frame!", 1'b0);
        send_pkt(1'b1, 1'b0);
        drain();

        mode = 1;
        for (int p = 0; p < 100; p++) begin
            int len = $urandom_range(1, 64);
            pkt_nm.delete();
            pkt_m.delete();
            for (int i = 0; i < len; i++) begin
                logic [7:0] b = 8'($urandom);
                pkt_nm.push_back(b);
                pkt_m.push_back($urandom_range(0, 3) == 0 ? 8'hFF : b);
            end
            send_pkt(1'(p), 1'b0);
        end
        drain();
        chk("beat_count", 64'(nbeats), 64'(npushed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
